// File: rtl/affine_loop_nest.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : affine_loop_nest                                            |
// | Description: Programmable DIMS-deep loop-nest walker that issues one     |
// |              iteration per II cycles with per-dim indices and an affine  |
// |              address. Optional checks: AFFINE_LOOP_NEST_CHECK_EN.        |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module affine_loop_nest #(
    parameter int DIMS   = 3,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 32,
    parameter int II     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIMS*CNT_W-1:0]    trips,
    input  logic [DIMS*ADDR_W-1:0]   strides,
    input  logic [ADDR_W-1:0]        base,
    input  logic                     ready,
    output logic                     valid,
    output logic [DIMS*CNT_W-1:0]    idx,
    output logic [ADDR_W-1:0]        addr,
    output logic                     last,
    output logic                     busy,
    output logic                     done
);

    localparam int                   c_gap_w    = (II > 1) ? $clog2(II) : 1;
    localparam logic [c_gap_w-1:0]   c_gap_load = c_gap_w'(II - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_trips    [DIMS];
    logic [CNT_W-1:0]    r_idx      [DIMS];
    logic [CNT_W-1:0]    w_idx_nxt  [DIMS];
    logic [ADDR_W-1:0]   r_strides  [DIMS];
    logic [ADDR_W-1:0]   r_wrap_sub [DIMS];
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_delta;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic                r_done;
    logic                r_pre;
    logic                w_any_zero;
    logic                w_last_all;
    logic                w_carry;

    always_comb begin
        w_any_zero = 1'b0;
        w_last_all = 1'b1;
        for (int d = 0; d < DIMS; d++) begin
            if (trips[d*CNT_W +: CNT_W] == '0) w_any_zero = 1'b1;
            if (r_idx[d] != r_trips[d] - 1'b1) w_last_all = 1'b0;
        end
    end

    // Odometer step: the first non-saturated dim increments, every dim below it wraps.
    always_comb begin
        w_carry = 1'b1;
        w_delta = '0;
        for (int d = 0; d < DIMS; d++) begin
            w_idx_nxt[d] = r_idx[d];
            if (w_carry) begin
                if (r_idx[d] == r_trips[d] - 1'b1) begin
                    w_idx_nxt[d] = '0;
                    w_delta      = w_delta - r_wrap_sub[d];
                end else begin
                    w_idx_nxt[d] = r_idx[d] + 1'b1;
                    w_delta      = w_delta + r_strides[d];
                    w_carry      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start && !w_any_zero) w_state_nxt = S_RUN;
            S_RUN: begin
                if (ready) begin
                    if (w_last_all)  w_state_nxt = S_IDLE;
                    else if (II > 1) w_state_nxt = S_GAP;
                end
            end
            S_GAP:   if (r_gap_cnt == c_gap_w'(1)) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_gap_cnt <= '0;
            r_done    <= 1'b0;
            r_pre     <= 1'b0;
            for (int d = 0; d < DIMS; d++) begin
                r_trips[d]    <= '0;
                r_idx[d]      <= '0;
                r_strides[d]  <= '0;
                r_wrap_sub[d] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_pre  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_any_zero) begin
                        r_done <= 1'b1;
                    end else if (start) begin
                        r_addr <= base;
                        r_pre  <= 1'b1;
                        // Zeroed wrap terms are exact for any wrap that can occur on the first step.
                        for (int d = 0; d < DIMS; d++) begin
                            r_trips[d]    <= trips[d*CNT_W +: CNT_W];
                            r_strides[d]  <= strides[d*ADDR_W +: ADDR_W];
                            r_idx[d]      <= '0;
                            r_wrap_sub[d] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (ready && w_last_all) begin
                        r_done <= 1'b1;
                    end else if (ready) begin
                        r_addr    <= r_addr + w_delta;
                        r_gap_cnt <= c_gap_load;
                        for (int d = 0; d < DIMS; d++) r_idx[d] <= w_idx_nxt[d];
                    end
                end
                S_GAP:   r_gap_cnt <= r_gap_cnt - 1'b1;
                default: ;
            endcase
            if (r_pre) begin
                for (int d = 0; d < DIMS; d++)
                    r_wrap_sub[d] <= ADDR_W'(r_trips[d] - 1'b1) * r_strides[d];
            end
        end
    end

    generate
        for (genvar d = 0; d < DIMS; d++) begin : g_idx_out
            assign idx[d*CNT_W +: CNT_W] = r_idx[d];
        end
    endgenerate

    assign valid = (r_state == S_RUN);
    assign busy  = (r_state != S_IDLE);
    assign last  = valid && w_last_all;
    assign addr  = r_addr;
    assign done  = r_done;

`ifdef AFFINE_LOOP_NEST_CHECK_EN
    logic                   r_chk_hold;
    logic [DIMS*CNT_W-1:0]  r_chk_idx;
    logic [ADDR_W-1:0]      r_chk_addr;
    logic                   r_chk_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_hold <= 1'b0;
            r_chk_idx  <= '0;
            r_chk_addr <= '0;
            r_chk_last <= 1'b0;
        end else begin
            if (start && busy) begin
                $display("ERROR: start asserted while busy");
                $finish(1);
            end
            if (ready && !valid) begin
                $display("ERROR: ready asserted while valid is low");
                $finish(1);
            end
            if (r_chk_hold && valid &&
                (idx != r_chk_idx || addr != r_chk_addr || last != r_chk_last)) begin
                $display("ERROR: iteration changed during stall");
                $finish(1);
            end
            r_chk_hold <= valid && !ready;
            r_chk_idx  <= idx;
            r_chk_addr <= addr;
            r_chk_last <= last;
        end
    end
`else
    // Checks compiled out; start while busy is simply ignored by the FSM.
`endif

endmodule
`default_nettype wire

// File: tb/tb_affine_loop_nest.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_affine_loop_nest                                         |
// | Description: Self-checking bench for affine_loop_nest (II=1 and II=3).   |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_affine_loop_nest;
    localparam int DIMS   = 3;
    localparam int CNT_W  = 16;
    localparam int ADDR_W = 32;
    localparam int II_B   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, start_a, start_b, ready;
    logic [DIMS*CNT_W-1:0]  trips;
    logic [DIMS*ADDR_W-1:0] strides;
    logic [ADDR_W-1:0]      base;
    logic                   valid_a, last_a, busy_a, done_a, valid_b, last_b, busy_b, done_b;
    logic [DIMS*CNT_W-1:0]  idx_a, idx_b;
    logic [ADDR_W-1:0]      addr_a, addr_b;

    affine_loop_nest #(.DIMS(DIMS), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .II(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .trips(trips), .strides(strides), .base(base),
        .ready(ready), .valid(valid_a), .idx(idx_a), .addr(addr_a), .last(last_a),
        .busy(busy_a), .done(done_a));

    affine_loop_nest #(.DIMS(DIMS), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .II(II_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .trips(trips), .strides(strides), .base(base),
        .ready(ready), .valid(valid_b), .idx(idx_b), .addr(addr_b), .last(last_b),
        .busy(busy_b), .done(done_b));

    bit                     sel;
    logic                   o_valid, o_last, o_busy, o_done;
    logic [DIMS*CNT_W-1:0]  o_idx;
    logic [ADDR_W-1:0]      o_addr;

    always_comb begin
        o_valid = sel ? valid_b : valid_a;
        o_last  = sel ? last_b  : last_a;
        o_busy  = sel ? busy_b  : busy_a;
        o_done  = sel ? done_b  : done_a;
        o_idx   = sel ? idx_b   : idx_a;
        o_addr  = sel ? addr_b  : addr_a;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: iteration k is a mixed-radix decomposition of k.
    int               m_trips   [DIMS];
    logic [31:0]      m_strides [DIMS];
    logic [31:0]      m_base;

    function automatic int m_total();
        int p = 1;
        for (int d = 0; d < DIMS; d++) p = p * m_trips[d];
        return p;
    endfunction

    function automatic logic [DIMS*CNT_W-1:0] m_idx(input int k);
        logic [DIMS*CNT_W-1:0] v = '0;
        int rem = k;
        for (int d = 0; d < DIMS; d++) begin
            v[d*CNT_W +: CNT_W] = CNT_W'(rem % m_trips[d]);
            rem = rem / m_trips[d];
        end
        return v;
    endfunction

    function automatic logic [31:0] m_addr(input int k);
        logic [31:0] a = m_base;
        int rem = k;
        for (int d = 0; d < DIMS; d++) begin
            a = a + m_strides[d] * 32'(rem % m_trips[d]);
            rem = rem / m_trips[d];
        end
        return a;
    endfunction

    // mode 0: ready high; 1: random ready plus start-while-busy noise; 2: 3-cycle stall on item 1
    task automatic run(input bit s, input logic [DIMS*CNT_W-1:0] t, input logic [DIMS*ADDR_W-1:0] st,
                       input logic [ADDR_W-1:0] b, input int mode, input bit chk_tab,
                       input int exp_cnt, input logic [ADDR_W-1:0] exp_last);
        int tot, k, since, pres1, ii;
        bit prev_hold;
        logic [DIMS*CNT_W-1:0] p_idx;
        logic [ADDR_W-1:0]     p_addr;
        for (int d = 0; d < DIMS; d++) begin
            m_trips[d]   = int'(t[d*CNT_W +: CNT_W]);
            m_strides[d] = st[d*ADDR_W +: ADDR_W];
        end
        m_base = b;
        tot = m_total();
        ii  = s ? II_B : 1;
        sel = s; trips = t; strides = st; base = b;
        ready = 1'b1;
        start_a = !s; start_b = s;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        if (tot == 0) begin
            check("empty_done", o_done, 1'b1);
            check("empty_valid", o_valid, 1'b0);
            check("empty_busy", o_busy, 1'b0);
            @(negedge clk);
            check("empty_done_pulse", o_done, 1'b0);
            check("empty_valid2", o_valid, 1'b0);
            return;
        end
        k = 0; since = 0; pres1 = 0; prev_hold = 1'b0; p_idx = '0; p_addr = '0;
        for (int cyc = 0; cyc < 2000 && k < tot; cyc++) begin
            check("early_done", o_done, 1'b0);
            if (o_valid) begin
                check("busy_in_run", o_busy, 1'b1);
                if (prev_hold) begin
                    check("stall_idx", o_idx, p_idx);
                    check("stall_addr", o_addr, p_addr);
                end else if (k > 0 && mode == 0) begin
                    check("cadence", since, ii);
                end
                if (k == 1) pres1++;
                case (mode)
                    0:       ready = 1'b1;
                    1:       ready = 1'($urandom_range(0, 1));
                    default: ready = !(k == 1 && pres1 <= 3);
                endcase
                if (ready) begin
                    check("idx", o_idx, m_idx(k));
                    check("addr", o_addr, m_addr(k));
                    check("last", o_last, (k == tot - 1));
                    k++;
                    since = 0;
                end
                prev_hold = !ready;
                p_idx = o_idx; p_addr = o_addr;
            end else begin
                prev_hold = 1'b0;
                ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                if (s) start_b = 1'b1; else start_a = 1'b1;
                trips = DIMS*CNT_W'({$urandom, $urandom});
                strides = {$urandom, $urandom, $urandom};
                base = $urandom;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            since++;
            @(negedge clk);
        end
        start_a = 1'b0; start_b = 1'b0; ready = 1'b1;
        check("accepted_count", k, tot);
        check("done", o_done, 1'b1);
        check("valid_after", o_valid, 1'b0);
        check("busy_after", o_busy, 1'b0);
        check("addr_hold", o_addr, m_addr(tot - 1));
        if (mode == 2) check("stall_hold_cycles", pres1, 4);
        if (chk_tab) begin
            check("tab_count", k, exp_cnt);
            check("tab_last_addr", o_addr, exp_last);
        end
    endtask

    typedef struct {
        bit                     s;
        logic [DIMS*CNT_W-1:0]  t;
        logic [DIMS*ADDR_W-1:0] st;
        logic [ADDR_W-1:0]      b;
        int                     mode;
        int                     exp_cnt;
        logic [ADDR_W-1:0]      exp_last;
    } vec_t;

    vec_t tab[9];

    initial begin
        tab[0] = '{0, {16'd1, 16'd2, 16'd3}, {32'd0, 32'd10, 32'd1}, 32'd100, 0, 6, 32'd112};
        tab[1] = '{0, {16'd1, 16'd2, 16'd3}, {32'd0, 32'd10, 32'd1}, 32'd100, 2, 6, 32'd112};
        tab[2] = '{0, {16'd1, 16'd1, 16'd1}, {32'd7, 32'd6, 32'd5}, 32'd42, 0, 1, 32'd42};
        tab[3] = '{0, {16'd1, 16'd1, 16'd4}, {32'd0, 32'd0, 32'd1}, 32'hFFFF_FFFE, 0, 4, 32'd1};
        tab[4] = '{0, {16'd5, 16'd0, 16'd2}, {32'd3, 32'd2, 32'd1}, 32'd9, 0, 0, 32'd0};
        tab[5] = '{0, {16'd2, 16'd3, 16'd2}, {32'd1000, 32'd100, 32'd4}, 32'd0, 1, 12, 32'd1204};
        tab[6] = '{0, {16'd2, 16'd1, 16'd3}, {32'd8, 32'd0, 32'hFFFF_FFFF}, 32'd10, 0, 6, 32'd16};
        tab[7] = '{1, {16'd1, 16'd2, 16'd3}, {32'd0, 32'd10, 32'd1}, 32'd100, 0, 6, 32'd112};
        tab[8] = '{1, {16'd2, 16'd3, 16'd2}, {32'd1000, 32'd100, 32'd4}, 32'd0, 1, 12, 32'd1204};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b0; sel = 1'b0;
        trips = '0; strides = '0; base = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", {valid_a, valid_b}, 2'b00);
        check("rst_busy", {busy_a, busy_b}, 2'b00);
        check("rst_done", {done_a, done_b}, 2'b00);
        check("rst_last", {last_a, last_b}, 2'b00);
        check("rst_idx", {idx_a, idx_b}, '0);
        check("rst_addr", {addr_a, addr_b}, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run(tab[i].s, tab[i].t, tab[i].st, tab[i].b, tab[i].mode, 1'b1, tab[i].exp_cnt, tab[i].exp_last);

        // II=3 single dim: valids on cycles 1,4,7,10 after start, done on 11.
        sel = 1'b1; ready = 1'b1;
        trips = {16'd1, 16'd1, 16'd4}; strides = {32'd0, 32'd0, 32'd4}; base = 32'd0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("ii3_valid_c%0d", c), o_valid, (c == 1 || c == 4 || c == 7 || c == 10));
            check($sformatf("ii3_done_c%0d", c), o_done, (c == 11));
            if (c == 1 || c == 4 || c == 7 || c == 10)
                check($sformatf("ii3_addr_c%0d", c), o_addr, 32'((c - 1) / 3 * 4));
            @(negedge clk);
        end

        // Reset while iteration 3 of 6 is presented: abort, no done, then a fresh run.
        sel = 1'b0; ready = 1'b1;
        trips = {16'd1, 16'd2, 16'd3}; strides = {32'd0, 32'd10, 32'd1}; base = 32'd100;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_addr", o_addr, 32'd102);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", o_valid, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_last", o_last, 1'b0);
        check("mid_rst_done", o_done, 1'b0);
        check("mid_rst_idx", o_idx, '0);
        check("mid_rst_addr", o_addr, '0);
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_done", o_done, 1'b0);
            check("post_rst_no_valid", o_valid, 1'b0);
        end
        run(tab[0].s, tab[0].t, tab[0].st, tab[0].b, 0, 1'b1, tab[0].exp_cnt, tab[0].exp_last);

        for (int i = 0; i < 16; i++) begin
            logic [DIMS*CNT_W-1:0] rt;
            for (int d = 0; d < DIMS; d++) rt[d*CNT_W +: CNT_W] = CNT_W'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) rt[$urandom_range(0, DIMS-1)*CNT_W +: CNT_W] = '0;
            run(i[0], rt, {$urandom, $urandom, $urandom}, $urandom, int'($urandom_range(0, 1)),
                1'b0, 0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
